pipe_latch_chain: RTL and testbench

PIPE_LATCH_CHAIN -- requirements
Module: pipe_latch_chain

---
 rtl/pipe_latch_chain_pkg.sv | 13 +
 rtl/VX_define.vh | 10 +
 rtl/pipe_slot.sv | 34 +++
 rtl/pipe_latch_chain.sv | 102 ++++++++++
 tb/tb_pipe_latch_chain.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_latch_chain_pkg.sv
// rtl/pipe_latch_chain_pkg.sv - shared constants and flush helper for the latch chain
`include "VX_define.vh"

package pipe_latch_chain_pkg;

    localparam int FLUSH_W = `PLC_FLUSH_W;

    // Out-of-range flush_stage values naturally cover every stage.
    function automatic logic flush_covers(input int idx, input logic [FLUSH_W-1:0] fs);
        return (idx <= int'(fs));
    endfunction

endpackage

// File: rtl/VX_define.vh
// rtl/VX_define.vh - shared default parameters for the latch chain
`ifndef VX_DEFINE_VH
`define VX_DEFINE_VH

`define PLC_NUM_STAGES 5
`define PLC_DATA_W 32
`define PLC_CNT_W 32
`define PLC_FLUSH_W 3

`endif

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one latch stage: valid bit plus payload, hold and flush-kill
`include "VX_define.vh"

module pipe_slot
    import pipe_latch_chain_pkg::*;
#(
    parameter int DATA_W = `PLC_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              kill,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Payload only moves with a valid entry so bubbles never toggle it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (kill) begin
            valid <= 1'b0;
        end else if (!hold) begin
            valid <= load_valid;
            if (load_valid) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/pipe_latch_chain.sv
// rtl/pipe_latch_chain.sv - elastic latch chain with stall, flush and perf counters
`include "VX_define.vh"

module pipe_latch_chain
    import pipe_latch_chain_pkg::*;
#(
    parameter int NUM_STAGES = `PLC_NUM_STAGES,
    parameter int DATA_W     = `PLC_DATA_W,
    parameter int CNT_W      = `PLC_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    input  logic [NUM_STAGES-1:0]        stall_req,
    input  logic                         flush_req,
    input  logic [FLUSH_W-1:0]           flush_stage,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0] stage_data,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             retire_count,
    output logic [CNT_W-1:0]             stall_count
);

    localparam int LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] v;
    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] kill;
    logic [NUM_STAGES-1:0] load_v;
    logic [DATA_W-1:0]     slot_data [NUM_STAGES];
    logic [DATA_W-1:0]     load_d    [NUM_STAGES];
    logic                  accept_ok;
    logic                  retire;

    // Walk from the oldest stage down; an empty stage breaks the chain.
    always_comb begin : hold_chain
        logic chain;
        hold  = '0;
        chain = ~out_ready;
        for (int i = LAST; i >= 0; i--) begin
            hold[i] = v[i] & (stall_req[i] | chain);
            chain   = hold[i];
        end
    end

    assign accept_ok = ~hold[0] & ~flush_req;
    assign in_ready  = ~reset | accept_ok;
    assign retire    = v[LAST] & out_ready & ~stall_req[LAST];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
        assign kill[i] = flush_req & flush_covers(i, flush_stage);

        if (i == 0) begin : g_entry
            assign load_v[i] = in_valid & accept_ok;
            assign load_d[i] = in_data;
        end else begin : g_chain
            assign load_v[i] = v[i-1] & ~hold[i-1] & ~kill[i-1];
            assign load_d[i] = slot_data[i-1];
        end

        pipe_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .hold      (hold[i]),
            .kill      (kill[i]),
            .load_valid(load_v[i]),
            .load_data (load_d[i]),
            .valid     (v[i]),
            .data      (slot_data[i])
        );

        assign stage_data[i*DATA_W +: DATA_W] = slot_data[i];
    end

    assign stage_valid = v;
    assign out_valid   = v[LAST];
    assign out_data    = slot_data[LAST];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count  <= '0;
            retire_count <= '0;
            stall_count  <= '0;
        end else begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (retire) begin
                retire_count <= retire_count + CNT_W'(1);
            end
            if (hold[0]) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_latch_chain.sv
// tb/tb_pipe_latch_chain.sv - randomized scoreboard bench for pipe_latch_chain
module tb_pipe_latch_chain;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_ready;
    logic [N-1:0]      stall_req = '0;
    logic              flush_req = 1'b0;
    logic [2:0]        flush_stage = '0;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b0;
    logic [N-1:0]      stage_valid;
    logic [N*DW-1:0]   stage_data;
    logic [CW-1:0]     cycle_count, retire_count, stall_count;

    int checks = 0;
    int failures = 0;
    int next_data = 1;

    logic [N-1:0]  mv;
    logic [DW-1:0] md [N];
    logic [CW-1:0] mc, mr, ms;

    pipe_latch_chain #(
        .NUM_STAGES(N),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall_req   (stall_req),
        .flush_req   (flush_req),
        .flush_stage (flush_stage),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .cycle_count (cycle_count),
        .retire_count(retire_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    // A stage is blocked if a contiguous run of valid stages above it ends in a blocker.
    function automatic logic [N-1:0] model_holds(input logic [N-1:0] st, input logic ordy);
        logic [N-1:0] h;
        h = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = i; j < N; j++) begin
                if (!mv[j]) break;
                if (st[j] || (j == N-1 && !ordy)) begin
                    h[i] = 1'b1;
                    break;
                end
            end
        end
        return h;
    endfunction

    task automatic model_clear();
        mv = '0;
        for (int i = 0; i < N; i++) md[i] = '0;
        mc = '0;
        mr = '0;
        ms = '0;
    endtask

    task automatic step(input logic iv, input logic [DW-1:0] id, input logic [N-1:0] st,
                        input logic fl, input logic [2:0] fs, input logic ordy);
        logic [N-1:0]  h, nv, killed;
        logic [DW-1:0] nd [N];
        logic [N*DW-1:0] exp_data;
        logic acc, inc;
        in_valid = iv; in_data = id; stall_req = st;
        flush_req = fl; flush_stage = fs; out_ready = ordy;
        h   = model_holds(st, ordy);
        acc = !h[0] && !fl;
        for (int i = 0; i < N; i++) killed[i] = fl && (i <= int'(fs));
        #1;
        checks++;
        if (in_ready !== acc) begin
            failures++;
            $display("FAIL in_ready got=%0b exp=%0b t=%0t", in_ready, acc, $time);
        end
        nv = mv;
        for (int i = 0; i < N; i++) nd[i] = md[i];
        for (int i = 0; i < N; i++) begin
            if (killed[i]) begin
                nv[i] = 1'b0;
            end else if (!h[i]) begin
                inc = (i == 0) ? (iv && acc) : (mv[i-1] && !h[i-1] && !killed[i-1]);
                nv[i] = inc;
                if (inc) nd[i] = (i == 0) ? id : md[i-1];
            end
        end
        if (mv[N-1] && ordy && !st[N-1]) mr = mr + 1'b1;
        if (h[0]) ms = ms + 1'b1;
        mc = mc + 1'b1;
        @(posedge clk);
        mv = nv;
        for (int i = 0; i < N; i++) md[i] = nd[i];
        @(negedge clk);
        for (int i = 0; i < N; i++) exp_data[i*DW +: DW] = md[i];
        checks++;
        if (stage_valid !== mv) begin
            failures++;
            $display("FAIL stage_valid got=%b exp=%b t=%0t", stage_valid, mv, $time);
        end
        checks++;
        if (stage_data !== exp_data) begin
            failures++;
            $display("FAIL stage_data got=%h exp=%h t=%0t", stage_data, exp_data, $time);
        end
        checks++;
        if (out_valid !== mv[N-1] || out_data !== md[N-1]) begin
            failures++;
            $display("FAIL out got=%0b/%0d exp=%0b/%0d t=%0t", out_valid, out_data, mv[N-1], md[N-1], $time);
        end
        checks++;
        if (cycle_count !== mc || retire_count !== mr || stall_count !== ms) begin
            failures++;
            $display("FAIL counters got=%0d/%0d/%0d exp=%0d/%0d/%0d t=%0t",
                     cycle_count, retire_count, stall_count, mc, mr, ms, $time);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_data = 32'hdead_beef; flush_req = 1'b1; out_ready = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (stage_valid !== '0 || stage_data !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b/%h/%0b/%h exp=0", stage_valid, stage_data, out_valid, out_data);
        end
        checks++;
        if (cycle_count !== '0 || retire_count !== '0 || stall_count !== '0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", cycle_count, retire_count, stall_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
        flush_req = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (stage_valid !== '0) begin
            failures++;
            $display("FAIL release_no_accept got=%b exp=0", stage_valid);
        end
    endtask

    task automatic test_fill();
        int first;
        logic [DW-1:0] first_data;
        first = 0;
        first_data = '0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, DW'(next_data), '0, 1'b0, 3'd0, 1'b1);
            next_data++;
            if (out_valid && first == 0) begin
                first = k;
                first_data = out_data;
            end
            if (k == 15) begin
                checks++;
                if (retire_count !== 10 || cycle_count !== 15) begin
                    failures++;
                    $display("FAIL fill_retire got=%0d/%0d exp=10/15", retire_count, cycle_count);
                end
            end
        end
        checks++;
        if (first !== 5 || first_data !== 1) begin
            failures++;
            $display("FAIL fill_first got=cycle%0d data%0d exp=cycle5 data1", first, first_data);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] snap [3];
        logic [CW-1:0] s0;
        s0 = ms;
        for (int i = 0; i < 3; i++) snap[i] = md[i];
        for (int k = 0; k < 3; k++) begin
            step(1'b1, DW'(next_data), 5'b00100, 1'b0, 3'd0, 1'b1);
            next_data++;
            checks++;
            if (stage_data[0 +: DW] !== snap[0] || stage_data[DW +: DW] !== snap[1] ||
                stage_data[2*DW +: DW] !== snap[2] || stage_valid[3] !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_freeze got=%h v3=%0b rdy=%0b exp=%h_%h_%h v3=0 rdy=0",
                         stage_data[3*DW-1:0], stage_valid[3], in_ready, snap[2], snap[1], snap[0]);
            end
        end
        checks++;
        if (stall_count !== s0 + 3) begin
            failures++;
            $display("FAIL stall_count got=%0d exp=%0d", stall_count, s0 + 3);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, DW'(next_data), '0, 1'b0, 3'd0, 1'b1);
            next_data++;
        end
    endtask

    task automatic test_collapse();
        logic [4:0] pat;
        pat = 5'b10101;
        step(1'b0, '0, '0, 1'b1, 3'd7, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(pat[k], DW'(next_data), '0, 1'b0, 3'd0, 1'b0);
            next_data++;
        end
        checks++;
        if (stage_valid !== 5'b10101) begin
            failures++;
            $display("FAIL collapse_setup got=%b exp=10101", stage_valid);
        end
        step(1'b1, DW'(next_data), '0, 1'b0, 3'd0, 1'b0);
        next_data++;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL collapse_ready_mid got=%0b exp=1", in_ready);
        end
        step(1'b1, DW'(next_data), '0, 1'b0, 3'd0, 1'b0);
        next_data++;
        checks++;
        if (stage_valid !== 5'b11111 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL collapse_full got=%b rdy=%0b exp=11111 rdy=0", stage_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [CW-1:0] r0;
        step(1'b0, '0, '0, 1'b1, 3'd7, 1'b0);
        for (int k = 1; k <= 5; k++) step(1'b1, DW'(k), '0, 1'b0, 3'd0, 1'b0);
        checks++;
        if (stage_data[4*DW +: DW] !== 1 || stage_data[0 +: DW] !== 5) begin
            failures++;
            $display("FAIL flush_setup got=%0d..%0d exp=1..5", stage_data[4*DW +: DW], stage_data[0 +: DW]);
        end
        step(1'b1, 32'd99, '0, 1'b1, 3'd2, 1'b0);
        checks++;
        if (stage_valid !== 5'b11000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_partial got=%b rdy=%0b exp=11000 rdy=0", stage_valid, in_ready);
        end
        r0 = retire_count;
        step(1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 2) begin
            failures++;
            $display("FAIL flush_order got=%0b/%0d exp=1/2", out_valid, out_data);
        end
        step(1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || retire_count !== r0 + 2) begin
            failures++;
            $display("FAIL flush_drain got=%0b/%0d exp=0/%0d", out_valid, retire_count, r0 + 2);
        end
    endtask

    task automatic test_flush_sat();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, DW'(next_data), '0, 1'b0, 3'd0, 1'b0);
            next_data++;
        end
        step(1'b1, DW'(next_data), 5'b11111, 1'b1, 3'd7, 1'b0);
        checks++;
        if (stage_valid !== '0) begin
            failures++;
            $display("FAIL flush_sat got=%b exp=00000", stage_valid);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] st;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) st[i] = ($urandom_range(0, 5) == 0);
            step(1'($urandom_range(0, 3) != 0), $urandom, st,
                 1'($urandom_range(0, 11) == 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 9) < 7));
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        #1;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) step(1'b1, DW'(k), '0, 1'b0, 3'd0, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (stage_valid !== '0 || stage_data !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b/%h/%0b/%h exp=0", stage_valid, stage_data, out_valid, out_data);
        end
        checks++;
        if (cycle_count !== '0 || retire_count !== '0 || stall_count !== '0) begin
            failures++;
            $display("FAIL midreset_counters got=%0d/%0d/%0d exp=0/0/0", cycle_count, retire_count, stall_count);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        checks++;
        if (cycle_count !== 3 || retire_count !== 0) begin
            failures++;
            $display("FAIL midreset_restart got=%0d/%0d exp=3/0", cycle_count, retire_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_collapse();
        test_flush();
        test_flush_sat();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
